sensor_conditioner: RTL

- Sits directly upstream of irrigation_state.
- Synchronises the three raw digital sensor inputs (soil humidity, air humidity, temperature) into the 50 MHz domain and debounces each one.
- On a sample request (the debounced init pulse), captures a coherent, settled snapshot that irrigation_state consumes.
- Also flags any post-capture change in a filtered sensor so the top level can re-evaluate.

---
 rtl/irrigation_pkg.sv | 14 +
 rtl/input_filter.sv | 37 +++
 rtl/sensor_conditioner.sv | 117 +++++++++++
 3 files changed

// File: rtl/irrigation_pkg.sv
// Shared types and default timing constants for the irrigation sensor front end.
package irrigation_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    WAIT_SETTLE = 2'b01,
    CAPTURE     = 2'b10
  } state_t;

  localparam int DEFAULT_STABLE_CYCLES  = 50000;
  localparam int DEFAULT_TIMEOUT_CYCLES = 5000000;
  localparam int DEFAULT_CW             = 23;

endpackage

// File: rtl/input_filter.sv
// One sensor channel: 2-flop synchroniser followed by a stability debouncer.
module input_filter #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CW            = 23
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic synced,
  output logic filtered
);

  logic          meta;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta     <= 1'b0;
      synced   <= 1'b0;
      filtered <= 1'b0;
      count    <= '0;
    end else begin
      meta   <= raw;
      synced <= meta;
      // Any return to the filtered value restarts the stability window.
      if (synced == filtered) begin
        count <= '0;
      end else if (count == CW'(STABLE_CYCLES - 1)) begin
        filtered <= synced;
        count    <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces the three sensor inputs and captures a settled snapshot on request,
// flagging later changes of any filtered channel against the captured value.
module sensor_conditioner
  import irrigation_pkg::*;
#(
  parameter int STABLE_CYCLES  = DEFAULT_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CW             = DEFAULT_CW
) (
  input  logic clk_50mhz,
  input  logic reset,
  input  logic soil_raw,
  input  logic air_raw,
  input  logic temp_raw,
  input  logic sample_req,
  output logic soil_o,
  output logic air_o,
  output logic temp_o,
  output logic sample_valid,
  output logic sample_stale,
  output logic busy,
  output logic change_pulse
);

  logic soil_sync, air_sync, temp_sync;
  logic soil_filt, air_filt, temp_filt;

  input_filter #(.STABLE_CYCLES(STABLE_CYCLES), .CW(CW)) u_soil (
    .clk(clk_50mhz), .reset(reset), .raw(soil_raw), .synced(soil_sync), .filtered(soil_filt)
  );
  input_filter #(.STABLE_CYCLES(STABLE_CYCLES), .CW(CW)) u_air (
    .clk(clk_50mhz), .reset(reset), .raw(air_raw), .synced(air_sync), .filtered(air_filt)
  );
  input_filter #(.STABLE_CYCLES(STABLE_CYCLES), .CW(CW)) u_temp (
    .clk(clk_50mhz), .reset(reset), .raw(temp_raw), .synced(temp_sync), .filtered(temp_filt)
  );

  logic settled;
  assign settled = (soil_sync == soil_filt) && (air_sync == air_filt) && (temp_sync == temp_filt);

  state_t        state, state_next;
  logic [CW-1:0] timeout_count, timeout_next;
  logic          stale_q, stale_d;

  always_comb begin
    state_next   = state;
    timeout_next = timeout_count;
    stale_d      = stale_q;
    case (state)
      IDLE: begin
        if (sample_req) begin
          state_next   = WAIT_SETTLE;
          timeout_next = '0;
        end
      end
      WAIT_SETTLE: begin
        if (settled) begin
          state_next = CAPTURE;
          stale_d    = 1'b0;
        end else if (timeout_count == CW'(TIMEOUT_CYCLES - 1)) begin
          state_next = CAPTURE;
          stale_d    = 1'b1;
        end else begin
          timeout_next = timeout_count + CW'(1);
        end
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timeout_count <= '0;
      stale_q       <= 1'b0;
    end else begin
      state         <= state_next;
      timeout_count <= timeout_next;
      stale_q       <= stale_d;
    end
  end

  assign busy = (state != IDLE);

  // armed: a capture has happened and no change has been reported since.
  logic armed;
  logic differs;
  assign differs = (soil_filt != soil_o) || (air_filt != air_o) || (temp_filt != temp_o);

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      soil_o       <= 1'b0;
      air_o        <= 1'b0;
      temp_o       <= 1'b0;
      sample_valid <= 1'b0;
      sample_stale <= 1'b0;
      change_pulse <= 1'b0;
      armed        <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      change_pulse <= 1'b0;
      if (state == CAPTURE) begin
        soil_o       <= soil_filt;
        air_o        <= air_filt;
        temp_o       <= temp_filt;
        sample_valid <= 1'b1;
        sample_stale <= stale_q;
        armed        <= 1'b1;
      end else if (state == IDLE && armed && differs) begin
        change_pulse <= 1'b1;
        armed        <= 1'b0;
      end
    end
  end

endmodule
